// File: rtl/hicore_test_monitor.sv
// hicore_test_monitor
// Watches the retirement stream of a core under test and decides when a
// test program has finished. A test ends in one of two ways: the core
// commits the tohost loop PC HIT_TARGET times (DONE), or the RUN-state
// cycle budget runs out first (TMO). Once the test ends, every reported
// value is frozen until the next reset. All outputs come straight from
// flops.
module hicore_test_monitor #(
  parameter logic [31:0] TOHOST_PC      = 32'h00000098,
  parameter int unsigned HIT_TARGET     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        commit_vld,
  input  logic [31:0] commit_pc,
  input  logic [31:0] x3_val,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
  output logic [7:0]  hit_cnt,
  output logic [31:0] end_cycle,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  // Hit count at which the next hit is the final one.
  localparam logic [7:0]  HIT_LAST = 8'(HIT_TARGET - 1);
  // Cycle count at which the current RUN cycle is the last one in budget.
  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping to zero, so a
  // very long run never reports a misleadingly small count.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic [31:0] end_cycle_q, end_cycle_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;

  logic        active_s;
  logic        hit_s;
  logic        final_hit_s;
  logic        budget_out_s;

  // Qualify this cycle's retirement: counting, tohost hits and end conditions.
  always_comb begin
    active_s     = (state_q == ST_RUN) && run_en;
    hit_s        = active_s && commit_vld && (commit_pc == TOHOST_PC);
    final_hit_s  = hit_s && (hit_cnt_q == HIT_LAST);
    // The final hit wins over an expiring budget in the same cycle.
    budget_out_s = active_s && (cycle_cnt_q == TMO_LAST) && !final_hit_s;
  end

  // Next-state and next-output computation; terminal states hold everything.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    end_cycle_d = end_cycle_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        // Retirements seen while idle belong to no test and are dropped.
        if (run_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (active_s) begin
          cycle_cnt_d = sat_inc32(cycle_cnt_q);

          if (commit_vld) begin
            instr_cnt_d = sat_inc32(instr_cnt_q);
          end else begin
            instr_cnt_d = instr_cnt_q;
          end

          if (hit_s) begin
            // HIT_TARGET is at most 255 and the test ends at the target,
            // so this count can never wrap.
            hit_cnt_d = hit_cnt_q + 8'd1;
            if (hit_cnt_q == 8'd0) begin
              end_cycle_d = cycle_cnt_q;
            end else begin
              end_cycle_d = end_cycle_q;
            end
          end else begin
            hit_cnt_d   = hit_cnt_q;
            end_cycle_d = end_cycle_q;
          end

          if (final_hit_s) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            pass_d    = (x3_val == 32'd1);
            timeout_d = 1'b0;
          end else if (budget_out_s) begin
            state_d   = ST_TMO;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            state_d   = ST_RUN;
          end
        end else begin
          // Paused: stay in RUN with every counter held.
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      ST_TMO: begin
        state_d = ST_TMO;
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle with no verdict.
        state_d     = ST_IDLE;
        cycle_cnt_d = 32'd0;
        instr_cnt_d = 32'd0;
        hit_cnt_d   = 8'd0;
        end_cycle_d = 32'd0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        timeout_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes priority over every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
      hit_cnt_q   <= 8'd0;
      end_cycle_q <= 32'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      end_cycle_q <= end_cycle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign hit_cnt   = hit_cnt_q;
  assign end_cycle = end_cycle_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_hicore_test_monitor.sv
// tb_hicore_test_monitor
// Directed bench for hicore_test_monitor with a 100-cycle budget. Each
// scenario pushes its expected end-of-test record when the stimulus that
// should produce it is driven, and pops/compares it when the monitor raises
// done or timeout.
module tb_hicore_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        commit_vld;
  logic [31:0] commit_pc;
  logic [31:0] x3_val;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic [7:0]  hit_cnt;
  logic [31:0] end_cycle;
  logic        done;
  logic        pass;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] TOHOST = 32'h00000098;

  typedef struct {
    string       tag;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] endc;
    logic [31:0] hits;
    logic        dn;
    logic        ps;
    logic        tm;
  } exp_t;

  exp_t exp_q[$];

  hicore_test_monitor #(
    .TOHOST_PC      (32'h00000098),
    .HIT_TARGET     (8),
    .TIMEOUT_CYCLES (32'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_en),
    .commit_vld (commit_vld),
    .commit_pc  (commit_pc),
    .x3_val     (x3_val),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
    .hit_cnt    (hit_cnt),
    .end_cycle  (end_cycle),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [31:0] pc, input logic [31:0] x3);
    run_en     = en;
    commit_vld = vld;
    commit_pc  = pc;
    x3_val     = x3;
  endtask

  task automatic repeat_steps(input int n, input logic en, input logic vld,
                              input logic [31:0] pc, input logic [31:0] x3);
    for (int i = 0; i < n; i++) begin
      drive(en, vld, pc, x3);
      step();
    end
    drive(en, 1'b0, 32'h0, x3);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check({tag, "_cycle"}, cycle_cnt, 32'd0);
    check({tag, "_instr"}, instr_cnt, 32'd0);
    check({tag, "_hit"},   32'(hit_cnt), 32'd0);
    check({tag, "_endc"},  end_cycle, 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_tmo"},   32'(timeout), 32'd0);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] cyc, input logic [31:0] ins,
                          input logic [31:0] endc, input logic [31:0] hits,
                          input logic dn, input logic ps, input logic tm);
    exp_t e;
    e.tag = tag; e.cyc = cyc; e.ins = ins; e.endc = endc; e.hits = hits;
    e.dn = dn; e.ps = ps; e.tm = tm;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for an end-of-test flag, then compare against the queue head.
  task automatic pop_check(input int budget);
    exp_t e;
    int   waited;
    waited = 0;
    while (!(done || timeout) && waited < budget) begin
      step();
      waited++;
    end
    check("end_flag_seen", 32'(done | timeout), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "_cycle"}, cycle_cnt, e.cyc);
      check({e.tag, "_instr"}, instr_cnt, e.ins);
      check({e.tag, "_endc"},  end_cycle, e.endc);
      check({e.tag, "_hit"},   32'(hit_cnt), e.hits);
      check({e.tag, "_done"},  32'(done), 32'(e.dn));
      check({e.tag, "_pass"},  32'(pass), 32'(e.ps));
      check({e.tag, "_tmo"},   32'(timeout), 32'(e.tm));
    end
  endtask

  // 20 ordinary commits, idle to cycle 50, then 8 tohost commits.
  task automatic run_basic(input string tag, input logic [31:0] x3, input logic exp_pass);
    do_reset({tag, "_rst"});
    // Idle commits at the tohost PC must be ignored.
    repeat_steps(3, 1'b0, 1'b1, TOHOST, x3);
    check({tag, "_idle_instr"}, instr_cnt, 32'd0);
    check({tag, "_idle_hit"},   32'(hit_cnt), 32'd0);
    // Transition edge: commit ignored, cycle count not started.
    repeat_steps(1, 1'b1, 1'b1, TOHOST, x3);
    check({tag, "_start_cycle"}, cycle_cnt, 32'd0);
    check({tag, "_start_instr"}, instr_cnt, 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(i) * 32'd4, x3);
      step();
    end
    repeat_steps(30, 1'b1, 1'b0, 32'h0, x3);
    check({tag, "_pre_cycle"}, cycle_cnt, 32'd50);
    check({tag, "_pre_instr"}, instr_cnt, 32'd20);
    push_exp(tag, 32'd58, 32'd28, 32'd50, 32'd8, 1'b1, exp_pass, 1'b0);
    repeat_steps(8, 1'b1, 1'b1, TOHOST, x3);
    pop_check(4);
    // Terminal: further activity changes nothing.
    repeat_steps(5, 1'b1, 1'b1, TOHOST, 32'd1);
    check({tag, "_frz_cycle"}, cycle_cnt, 32'd58);
    check({tag, "_frz_hit"},   32'(hit_cnt), 32'd8);
    check({tag, "_frz_pass"},  32'(pass), 32'(exp_pass));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Passing and failing result register.
    run_basic("pass_run", 32'd1, 1'b1);
    run_basic("fail_run", 32'd3, 1'b0);

    // Budget expiry with no tohost commits.
    do_reset("tmo_rst");
    repeat_steps(1, 1'b1, 1'b1, 32'h200, 32'd1);
    repeat_steps(99, 1'b1, 1'b1, 32'h200, 32'd1);
    check("tmo_at99_cycle", cycle_cnt, 32'd99);
    check("tmo_at99_flag",  32'(timeout), 32'd0);
    push_exp("tmo", 32'd100, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat_steps(1, 1'b1, 1'b1, 32'h200, 32'd1);
    pop_check(4);
    repeat_steps(5, 1'b1, 1'b1, TOHOST, 32'd1);
    check("tmo_frz_cycle", cycle_cnt, 32'd100);
    check("tmo_frz_hit",   32'(hit_cnt), 32'd0);
    check("tmo_frz_done",  32'(done), 32'd0);

    // Final hit lands on the last budget cycle: DONE wins.
    do_reset("edge_rst");
    repeat_steps(1, 1'b1, 1'b0, 32'h0, 32'd1);
    repeat_steps(92, 1'b1, 1'b0, 32'h0, 32'd1);
    check("edge_pre_cycle", cycle_cnt, 32'd92);
    push_exp("edge", 32'd100, 32'd8, 32'd92, 32'd8, 1'b1, 1'b1, 1'b0);
    repeat_steps(8, 1'b1, 1'b1, TOHOST, 32'd1);
    pop_check(4);

    // Pause mid-run with tohost commits on the bus.
    do_reset("gap_rst");
    repeat_steps(1, 1'b1, 1'b0, 32'h0, 32'd1);
    repeat_steps(10, 1'b1, 1'b0, 32'h0, 32'd1);
    repeat_steps(3, 1'b1, 1'b1, TOHOST, 32'd1);
    check("gap_pre_cycle", cycle_cnt, 32'd13);
    check("gap_pre_hit",   32'(hit_cnt), 32'd3);
    repeat_steps(10, 1'b0, 1'b1, TOHOST, 32'd1);
    check("gap_post_cycle", cycle_cnt, 32'd13);
    check("gap_post_instr", instr_cnt, 32'd3);
    check("gap_post_hit",   32'(hit_cnt), 32'd3);
    check("gap_post_done",  32'(done), 32'd0);
    push_exp("gap", 32'd18, 32'd8, 32'd10, 32'd8, 1'b1, 1'b1, 1'b0);
    repeat_steps(5, 1'b1, 1'b1, TOHOST, 32'd1);
    pop_check(4);

    // Reset in the middle of a run, then a fresh complete test.
    do_reset("mid_rst0");
    repeat_steps(1, 1'b1, 1'b0, 32'h0, 32'd1);
    repeat_steps(5, 1'b1, 1'b1, TOHOST, 32'd1);
    check("mid_hit5", 32'(hit_cnt), 32'd5);
    rst = 1'b1;
    drive(1'b1, 1'b1, TOHOST, 32'd1);
    step();
    rst = 1'b0;
    check("mid_rst_cycle", cycle_cnt, 32'd0);
    check("mid_rst_hit",   32'(hit_cnt), 32'd0);
    check("mid_rst_endc",  end_cycle, 32'd0);
    check("mid_rst_done",  32'(done), 32'd0);
    repeat_steps(1, 1'b1, 1'b0, 32'h0, 32'd1);
    check("mid_start_cycle", cycle_cnt, 32'd0);
    push_exp("mid", 32'd8, 32'd8, 32'd0, 32'd8, 1'b1, 1'b1, 1'b0);
    repeat_steps(8, 1'b1, 1'b1, TOHOST, 32'd1);
    pop_check(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hicore_test_monitor.md
HICORE_TEST_MONITOR -- requirements
Module: hicore_test_monitor

Interface
REQ-001 SHALL have parameter TOHOST_PC, default 32'h00000098, the commit PC that marks the end-of-test loop.
REQ-002 SHALL have parameter HIT_TARGET, default 8, the number of TOHOST_PC commits that ends the test; legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd10000000, the RUN-state cycle budget; must be at least 1.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port run_en  input  1  level; enables counting (IDLE->RUN; pauses in RUN when low).
REQ-007 SHALL have port commit_vld  input  1  one instruction retired this cycle.
REQ-008 SHALL have port commit_pc  input  32  PC of the retired instruction; qualified by commit_vld.
REQ-009 SHALL have port x3_val  input  32  current architectural x3 (test result register).
REQ-010 SHALL have port cycle_cnt  output  32  RUN cycles counted.
REQ-011 SHALL have port instr_cnt  output  32  retired instructions counted.
REQ-012 SHALL have port hit_cnt  output  8  TOHOST_PC commits counted.
REQ-013 SHALL have port end_cycle  output  32  cycle_cnt value at the first TOHOST_PC commit.
REQ-014 SHALL have ports done, pass, timeout  output  1 each  end-of-test status flags, registered.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE, TMO; IDLE is entered on reset.
REQ-016 SHALL move IDLE->RUN on the cycle after run_en is sampled high; commits during IDLE are ignored.
REQ-017 SHALL, in RUN with run_en=1, increment cycle_cnt by 1 each cycle; with run_en=0 all counters hold and the state stays RUN.
REQ-018 SHALL, in RUN with run_en=1, increment instr_cnt when commit_vld=1.
REQ-019 SHALL define a hit as RUN & run_en & commit_vld & (commit_pc==TOHOST_PC) and increment hit_cnt on each hit.
REQ-020 SHALL, on the first hit (hit_cnt==0), load end_cycle with the pre-increment cycle_cnt; later hits leave end_cycle unchanged.
REQ-021 SHALL, on a hit with hit_cnt==HIT_TARGET-1, go to DONE next cycle, set done=1, and set pass=(x3_val==32'd1) sampled in the hit cycle.
REQ-022 SHALL, in RUN with run_en=1 and cycle_cnt==TIMEOUT_CYCLES-1 and no final hit that cycle, go to TMO next cycle, set timeout=1, pass=0.
REQ-023 SHALL give the final hit priority over timeout when both occur in the same cycle (DONE, timeout stays 0).
REQ-024 SHALL saturate cycle_cnt and instr_cnt at 32'hFFFFFFFF (no wrap).
REQ-025 SHALL treat DONE and TMO as terminal: all counters, end_cycle and flags frozen, inputs ignored, until rst.
REQ-026 SHALL keep done and timeout mutually exclusive; pass=1 only together with done=1.
REQ-027 SHALL have all outputs driven directly from registers (no combinational input-to-output path).

Reset
REQ-028 SHALL, when rst=1 at a rising edge, set state=IDLE and cycle_cnt, instr_cnt, hit_cnt, end_cycle, done, pass, timeout all to 0.
REQ-029 SHALL give rst priority over every other event, including mid-RUN and in DONE/TMO; a new test starts only via IDLE->RUN.

Verification
REQ-030 SHALL be verified: run_en=1, 20 commits of non-tohost PCs, then 8 commits at PC 0x98 starting at cycle_cnt=50, x3_val=1 -> end_cycle=50, instr_cnt=28, hit_cnt=8, done=1, pass=1, timeout=0.
REQ-031 SHALL be verified: same sequence with x3_val=3 -> done=1, pass=0.
REQ-032 SHALL be verified: TIMEOUT_CYCLES=100, no tohost commits -> timeout=1 one cycle after cycle_cnt reaches 99, cycle_cnt frozen at 100, done=0.
REQ-033 SHALL be verified: TIMEOUT_CYCLES=100, 8th hit at cycle_cnt=99 -> done=1, timeout=0.
REQ-034 SHALL be verified: run_en low for 10 cycles mid-RUN with commit_vld=1 and PC 0x98 -> cycle_cnt, instr_cnt, hit_cnt unchanged across the gap.
REQ-035 SHALL be verified: rst pulsed after 5 hits, then run_en=1 -> all outputs 0, IDLE->RUN, a fresh 8-hit sequence completes with done=1.
